// File: rtl/arb_pkg.sv
// Shared types for the round-robin / fixed-priority request arbiter.
//   arb_mode_e  : arbitration policy selected at each arbitration point
//   arb_state_e : ownership state of the shared resource
package arb_pkg;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    typedef enum logic {
        ARB_IDLE,
        ARB_OWNED
    } arb_state_e;

endpackage : arb_pkg

// File: rtl/arb_rr_pick.sv
// Combinational winner picker for the arbiter.
//   request    : N-bit request vector
//   pointer    : round-robin search start index (ignored in fixed mode)
//   mode       : ARB_RR (search from pointer, wrapping) or ARB_FIXED (lowest index)
//   exclude    : requesters removed from consideration
//   winner     : one-hot winner, all-zero when nothing eligible
//   winner_idx : binary index of winner, 0 when nothing eligible
//   any_valid  : at least one eligible requester
module arb_rr_pick
    import arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   request,
    input  logic [IDW-1:0] pointer,
    input  logic           mode,
    input  logic [N-1:0]   exclude,
    output logic [N-1:0]   winner,
    output logic [IDW-1:0] winner_idx,
    output logic           any_valid
);

    logic [N-1:0]   masked;
    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;
    logic           found;

    always_comb begin
        masked     = request & ~exclude;
        found      = 1'b0;
        winner_idx = '0;
        sum        = '0;
        idx        = '0;
        for (int k = 0; k < N; k++) begin
            // One extra bit holds pointer+k (< 2N) before the modulo-N fold.
            sum = {1'b0, pointer} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(N)) begin
                sum = sum - (IDW+1)'(N);
            end
            if (mode == ARB_FIXED) begin
                idx = IDW'(k);
            end else begin
                idx = sum[IDW-1:0];
            end
            if (!found && masked[idx]) begin
                found      = 1'b1;
                winner_idx = idx;
            end
        end
        any_valid = found;
        winner    = found ? (N'(1) << winner_idx) : '0;
    end

endmodule : arb_rr_pick

// File: rtl/arb_rr_port.sv
// N-way request/grant arbiter with registered one-hot grants.
//   clk, rst    : clock, synchronous active-high reset
//   request     : per-requester level request
//   mode        : 0 round-robin, 1 fixed priority; used only when a new owner is chosen
//   grant       : registered one-hot (or zero) grant
//   grant_valid : grant is non-zero
//   grant_id    : binary index of current owner, 0 when idle
// An owner keeps the grant while it requests; after HOLD_MAX consecutive
// cycles it is forced to yield if anyone else is waiting.
module arb_rr_port
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int HOLD_MAX = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         request,
    input  logic                 mode,
    output logic [N-1:0]         grant,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] grant_id
);

    localparam int IDW = $clog2(N);
    localparam int HW  = $clog2(HOLD_MAX + 1);
    localparam logic [HW-1:0] HOLD_LIM = HW'(HOLD_MAX);

    arb_state_e     state_q, state_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [IDW-1:0] id_q, id_d;
    logic           valid_q, valid_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [HW-1:0]  hold_q, hold_d;

    logic           owner_req;
    logic           others_req;
    logic           hold_expired;
    logic [N-1:0]   pick_excl;
    logic [N-1:0]   pick_onehot;
    logic [IDW-1:0] pick_idx;
    logic           pick_any;
    logic           take;

    assign owner_req    = request[id_q];
    assign others_req   = |(request & ~grant_q);
    assign hold_expired = (hold_q == HOLD_LIM);

    // The owner is only masked out when its hold budget is spent; when it
    // has dropped its request it is ineligible anyway.
    assign pick_excl = (state_q == ARB_OWNED && owner_req && hold_expired) ? grant_q : '0;

    arb_rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .request    (request),
        .pointer    (ptr_q),
        .mode       (mode),
        .exclude    (pick_excl),
        .winner     (pick_onehot),
        .winner_idx (pick_idx),
        .any_valid  (pick_any)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        id_d    = id_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        take    = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                take = pick_any;
            end
            ARB_OWNED: begin
                if (owner_req) begin
                    if (!hold_expired) begin
                        hold_d = hold_q + HW'(1);
                    end else if (others_req) begin
                        take = 1'b1;
                    end else begin
                        // Sole requester: keep the grant, restart the budget.
                        hold_d = HW'(1);
                    end
                end else if (pick_any) begin
                    // Same-edge handoff, no bubble cycle.
                    take = 1'b1;
                end else begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                    id_d    = '0;
                    valid_d = 1'b0;
                    hold_d  = '0;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        if (take) begin
            state_d = ARB_OWNED;
            grant_d = pick_onehot;
            id_d    = pick_idx;
            valid_d = 1'b1;
            hold_d  = HW'(1);
            ptr_d   = (pick_idx == IDW'(N - 1)) ? '0 : pick_idx + IDW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            id_q    <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = valid_q;
    assign grant_id    = id_q;

endmodule : arb_rr_port

// File: tb/tb_arb_rr_port.sv
module tb_arb_rr_port;

    localparam int N  = 4;
    localparam int HM = 4;

    logic         clk;
    logic         rst;
    logic [N-1:0] request;
    logic         mode;
    logic [N-1:0] grant;
    logic         grant_valid;
    logic [1:0]   grant_id;

    int n_checks = 0;
    int n_fail   = 0;

    arb_rr_port #(
        .N        (N),
        .HOLD_MAX (HM)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .request     (request),
        .mode        (mode),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: owner index (-1 = nobody), rotation pointer, hold count.
    int  m_owner = -1;
    int  m_ptr   = 0;
    int  m_hold  = 0;
    bit  m_ok    = 1'b0;

    function automatic int pick(logic [N-1:0] req, int ptr, bit fixed, logic [N-1:0] excl);
        for (int k = 0; k < N; k++) begin
            int i;
            i = fixed ? k : (ptr + k) % N;
            if (req[i] && !excl[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] bit_of(int i);
        logic [N-1:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    always @(posedge clk) begin
        int w;
        w = -1;
        if (rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_hold  = 0;
            m_ok    = 1'b1;
        end else if (m_owner < 0) begin
            w = pick(request, m_ptr, mode, '0);
        end else if (request[m_owner]) begin
            if (m_hold < HM) begin
                m_hold++;
            end else if ((request & ~bit_of(m_owner)) != '0) begin
                w = pick(request, m_ptr, mode, bit_of(m_owner));
            end else begin
                m_hold = 1;
            end
        end else begin
            w = pick(request, m_ptr, mode, '0);
            if (w < 0) begin
                m_owner = -1;
                m_hold  = 0;
            end
        end
        if (!rst && w >= 0) begin
            m_owner = w;
            m_hold  = 1;
            m_ptr   = (w + 1) % N;
        end
    end

    // Compare process: every cycle once the model has seen a reset.
    always @(negedge clk) begin
        if (m_ok) begin
            chk("model_grant", 32'(grant), 32'(bit_of(m_owner)));
            chk("model_valid", 32'(grant_valid), 32'(m_owner >= 0));
            chk("model_id", 32'(grant_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        end
    end

    // Apply inputs just after an edge, then wait for the next edge + 1.
    task automatic step(input logic r, input logic [N-1:0] q, input logic m);
        rst     = r;
        request = q;
        mode    = m;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        request = 4'b1111;
        mode    = 1'b0;
        #1;

        // Reset with all requests active.
        for (int c = 0; c < 2; c++) begin
            step(1'b1, 4'b1111, 1'b0);
            chk("reset_grant", 32'(grant), 32'h0);
            chk("reset_valid", 32'(grant_valid), 32'h0);
            chk("reset_id", 32'(grant_id), 32'h0);
        end

        // Round-robin rotation under the hold limit.
        for (int c = 0; c < 17; c++) begin
            logic [3:0] e;
            e = 4'b0001 << ((c / 4) % 4);
            step(1'b0, 4'b1111, 1'b0);
            chk("rr_rotate", 32'(grant), 32'(e));
        end

        // Fixed priority and zero-bubble handoff.
        step(1'b0, 4'b1010, 1'b1);
        chk("fixed_grant", 32'(grant), 32'h2);
        chk("fixed_id", 32'(grant_id), 32'h1);
        chk("fixed_valid", 32'(grant_valid), 32'h1);
        step(1'b0, 4'b1000, 1'b1);
        chk("handoff_grant", 32'(grant), 32'h8);
        chk("handoff_valid", 32'(grant_valid), 32'h1);
        chk("handoff_id", 32'(grant_id), 32'h3);

        // Sole requester past the hold limit.
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 4'b0100, 1'b0);
            chk("sole_grant", 32'(grant), 32'h4);
            chk("sole_valid", 32'(grant_valid), 32'h1);
        end
        step(1'b0, 4'b0000, 1'b0);
        chk("drop_grant", 32'(grant), 32'h0);
        chk("drop_valid", 32'(grant_valid), 32'h0);

        // One-cycle latency.
        request = 4'b0001;
        #2;
        chk("latency_before", 32'(grant), 32'h0);
        @(posedge clk);
        #1;
        chk("latency_after", 32'(grant), 32'h1);
        step(1'b0, 4'b0000, 1'b0);

        // Reset mid-grant restores the pointer to 0.
        step(1'b0, 4'b0100, 1'b0);
        chk("pre_reset_grant", 32'(grant), 32'h4);
        step(1'b1, 4'b0100, 1'b0);
        chk("mid_reset_grant", 32'(grant), 32'h0);
        chk("mid_reset_valid", 32'(grant_valid), 32'h0);
        step(1'b0, 4'b1111, 1'b0);
        chk("post_reset_grant", 32'(grant), 32'h1);

        // Randomised traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            logic [N-1:0] q;
            logic         r;
            logic         m;
            q = N'($urandom);
            if ($urandom_range(0, 3) == 0) q = q & N'($urandom);
            m = ($urandom_range(0, 7) == 0) ? ~mode : mode;
            r = ($urandom_range(0, 99) == 0);
            // Runs of steady requests exercise the hold limit.
            if ($urandom_range(0, 1) == 0 && !r) q = request;
            step(r, q, m);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_arb_rr_port

// File: doc/arb_rr_port.md
# arb_rr_port

Parametrised N-way request/grant arbiter with registered one-hot grants. It selects per-arbitration between round-robin and fixed-priority modes. A per-owner hold limit prevents a requester from starving others. It sits between N requesting masters and a single shared resource, replacing the fixed 2-bit arbiter port in the next-generation testbench/DUT pairing.

## Interface
- N, default 4: number of requesters; legal range 2..16.
- HOLD_MAX, default 8: maximum consecutive grant cycles for one owner while any other requester is active; must be ≥1.
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset, sampled on posedge clk.
- request  input  N  request vector; bit i asserted means requester i wants the resource; level-sensitive.
- mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins); sampled only at arbitration points.
- grant  output  N  one-hot (or all-zero) registered grant.
- grant_valid  output  1  high when grant is non-zero.
- grant_id  output  $clog2(N)  binary index of current owner; 0 when grant_valid=0.

## Operation
- States: IDLE (no owner) and OWNED (one owner, grant held).
- IDLE → OWNED: any request bit set at a posedge. The winner from the picker is granted at that edge. hold_cnt is set to 1.
- OWNED, owner still requesting, hold_cnt < HOLD_MAX: keep grant and increment hold_cnt.
- OWNED, owner still requesting, hold_cnt == HOLD_MAX:
  - If another requester is active, re-arbitrate with the current owner excluded, grant the winner, and set hold_cnt to 1.
  - If the owner is the sole requester, keep the grant and set hold_cnt to 1.
- OWNED, owner drops its request: re-arbitrate at the same edge.
  - Any other request present: grant the new winner. There is no bubble cycle.
  - No requests present: go to IDLE with grant all-zero.
- Round-robin pointer:
  - After a grant to index i, the pointer becomes (i+1) mod N.
  - The search starts at the pointer and wraps N-1 → 0.
  - The pointer updates only when a new owner is granted, in either mode.
- Fixed mode: lowest set index wins. The pointer is ignored but is still updated.
- mode changes mid-ownership do not preempt the owner. The new mode applies at the next arbitration point.
- grant is always one-hot or zero. grant, grant_id and grant_valid are mutually consistent in every cycle.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Latency: a request driven after edge t is sampled at edge t+1, and grant reflects it after edge t+1 (one cycle).
- Handoff: the owner deasserts request after edge t; the new owner is visible after edge t+1, in the same cycle that the old grant drops.
- Reset values (rst high at a posedge):
  - grant=0, grant_valid=0, grant_id=0.
  - pointer=0, hold_cnt=0, state=IDLE.
- Reset overrides everything, including mid-ownership: grant drops after that edge.
- First arbitration after reset releases at edge t is at edge t+1, with requester 0 highest priority.
- hold_cnt width is $clog2(HOLD_MAX+1), and the counter saturates at HOLD_MAX. With HOLD_MAX=1, arbitration happens every cycle when contended.

## Structure
- Package arb_pkg contains:
  - typedef enum {ARB_RR=1'b0, ARB_FIXED=1'b1} arb_mode_e.
  - typedef enum {ARB_IDLE, ARB_OWNED} arb_state_e.
- Sub-module arb_rr_pick (combinational, parametrised by N):
  - Inputs: request, pointer, mode, exclude mask.
  - Outputs: one-hot winner, winner index, any_valid.
- Top module: state register, pointer, hold counter, output registers.

## Test plan
Unless stated otherwise, N=4 and HOLD_MAX=4.
- Reset: rst=1 for 2 cycles with request=4'b1111 → grant=4'b0000, grant_valid=0, grant_id=0 throughout.
- Round-robin rotation under hold limit: mode=0, request=4'b1111 held → grant is 0001 for 4 cycles, then 0010 ×4, 0100 ×4, 1000 ×4, then 0001 again.
- Fixed priority with zero-bubble handoff: mode=1, request=4'b1010 → grant=0010, grant_id=1. Then request=4'b1000 → grant=1000 after the next edge, with grant_valid continuously 1.
- Sole requester exceeding hold: request=4'b0100 for 10 cycles → grant=0100 and grant_valid=1 on all 10 cycles, with no gap. Dropping the request → grant=0000 one edge later.
- Latency check: request goes 0000 → 0001 after edge t → grant=0001 after edge t+1, and not before.
- Reset mid-grant: with grant=0100, pulse rst for one cycle, then request=4'b1111 in mode 0 → grant=0000 after the reset edge, then 0001 (pointer restored to 0).
